// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - Tetris gravity/move tick sequencer with game phase FSM
package tetris_pkg;
    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_LEFT   = 3'd1,
        CMD_RIGHT  = 3'd2,
        CMD_ROTATE = 3'd3,
        CMD_DROP   = 3'd4
    } command_t;
endpackage

module game_tick_scheduler #(
    parameter int GRAVITY_BASE    = 12_000_000,
    parameter int GRAVITY_STEP    = 1_000_000,
    parameter int GRAVITY_MIN     = 1_500_000,
    parameter int MAX_LEVEL       = 9,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MOVE_GAP        = 2_000_000,
    parameter int CLEAR_PERIOD    = 500_000,
    parameter int CNT_W           = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                pause_toggle,
    input  logic                soft_drop,
    input  logic                move_req,
    input  tetris_pkg::command_t move_cmd,
    input  logic                line_clear_active,
    input  logic                game_over,
    output logic                gravity_tick,
    output logic                move_grant,
    output tetris_pkg::command_t move_cmd_out,
    output logic [2:0]          state,
    output logic [3:0]          level,
    output logic [15:0]         lines
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_CLEAR = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] BASE_C       = CNT_W'(GRAVITY_BASE);
    localparam logic [CNT_W-1:0] STEP_C       = CNT_W'(GRAVITY_STEP);
    localparam logic [CNT_W-1:0] MIN_C        = CNT_W'(GRAVITY_MIN);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(MOVE_GAP - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_PERIOD - 1);
    localparam logic [CNT_W-1:0] SUB_LAST     = CNT_W'(LINES_PER_LEVEL - 1);
    localparam logic [3:0]       LVL_MAX      = 4'(MAX_LEVEL);

    state_t                st;
    logic [CNT_W-1:0]      grav_cnt;
    logic [CNT_W-1:0]      gap_cnt;
    logic [CNT_W-1:0]      lvl_sub;
    logic [CNT_W-1:0]      drop_amt;
    logic [CNT_W-1:0]      period;
    logic                  pend_valid;
    tetris_pkg::command_t  pend_cmd;
    logic                  tick_due;
    logic                  grant_ok;
    tetris_pkg::command_t  grant_src;

    assign state = st;

    // Gravity period for the current level, floored, then quartered during soft drop
    always_comb begin
        drop_amt = CNT_W'(level) * STEP_C;
        if ((drop_amt + MIN_C) >= BASE_C)
            period = MIN_C;
        else
            period = BASE_C - drop_amt;
        if (soft_drop)
            period = period >> 2;
    end

    // Tick and grant eligibility; a fresh request bypasses the buffer and beats an older one
    always_comb begin
        tick_due  = (grav_cnt + CNT_W'(1)) >= period;
        grant_src = move_req ? move_cmd : pend_cmd;
        grant_ok  = (move_req || pend_valid) && (gap_cnt == '0) && !tick_due;
    end

    // Phase FSM, counters, move arbitration and line/level accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= S_IDLE;
            gravity_tick <= 1'b0;
            move_grant   <= 1'b0;
            move_cmd_out <= tetris_pkg::CMD_NONE;
            level        <= 4'd0;
            lines        <= 16'd0;
            lvl_sub      <= '0;
            grav_cnt     <= '0;
            gap_cnt      <= '0;
            pend_valid   <= 1'b0;
            pend_cmd     <= tetris_pkg::CMD_NONE;
        end else begin
            gravity_tick <= 1'b0;
            move_grant   <= 1'b0;
            move_cmd_out <= tetris_pkg::CMD_NONE;
            case (st)
                S_IDLE, S_OVER: begin
                    pend_valid <= 1'b0;
                    if (start) begin
                        st       <= S_RUN;
                        level    <= 4'd0;
                        lines    <= 16'd0;
                        lvl_sub  <= '0;
                        grav_cnt <= '0;
                        gap_cnt  <= '0;
                        pend_cmd <= tetris_pkg::CMD_NONE;
                    end
                end
                S_RUN: begin
                    if (game_over) begin
                        st         <= S_OVER;
                        pend_valid <= 1'b0;
                    end else if (line_clear_active) begin
                        st         <= S_CLEAR;
                        grav_cnt   <= '0;
                        pend_valid <= 1'b0;
                        if (lines != 16'hFFFF)
                            lines <= lines + 16'd1;
                        if (lvl_sub >= SUB_LAST) begin
                            lvl_sub <= '0;
                            if (level < LVL_MAX)
                                level <= level + 4'd1;
                        end else begin
                            lvl_sub <= lvl_sub + CNT_W'(1);
                        end
                    end else if (pause_toggle) begin
                        st <= S_PAUSE;
                    end else begin
                        if (tick_due) begin
                            gravity_tick <= 1'b1;
                            grav_cnt     <= '0;
                        end else begin
                            grav_cnt <= grav_cnt + CNT_W'(1);
                        end
                        if (grant_ok) begin
                            move_grant   <= 1'b1;
                            move_cmd_out <= grant_src;
                            pend_valid   <= 1'b0;
                            gap_cnt      <= GAP_LOAD;
                        end else begin
                            if (gap_cnt != '0)
                                gap_cnt <= gap_cnt - CNT_W'(1);
                            if (move_req) begin
                                pend_valid <= 1'b1;
                                pend_cmd   <= move_cmd;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (game_over) begin
                        st         <= S_OVER;
                        pend_valid <= 1'b0;
                    end else if (pause_toggle) begin
                        st <= S_RUN;
                    end
                end
                S_CLEAR: begin
                    if (gap_cnt != '0)
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    if (game_over) begin
                        st <= S_OVER;
                    end else if (!line_clear_active) begin
                        st       <= S_RUN;
                        grav_cnt <= '0;
                    end else if (grav_cnt >= CLEAR_LAST) begin
                        gravity_tick <= 1'b1;
                        grav_cnt     <= '0;
                    end else begin
                        grav_cnt <= grav_cnt + CNT_W'(1);
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb/tb_game_tick_scheduler.sv - directed self-checking bench for game_tick_scheduler
module tb_game_tick_scheduler;
    import tetris_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause_toggle = 1'b0;
    logic       soft_drop = 1'b0;
    logic       move_req = 1'b0;
    command_t   move_cmd = CMD_NONE;
    logic       line_clear_active = 1'b0;
    logic       game_over = 1'b0;
    logic       gravity_tick;
    logic       move_grant;
    command_t   move_cmd_out;
    logic [2:0] state;
    logic [3:0] level;
    logic [15:0] lines;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    game_tick_scheduler #(
        .GRAVITY_BASE(20), .GRAVITY_STEP(4), .GRAVITY_MIN(8), .MAX_LEVEL(3),
        .LINES_PER_LEVEL(2), .MOVE_GAP(3), .CLEAR_PERIOD(2), .CNT_W(24)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause_toggle(pause_toggle),
        .soft_drop(soft_drop), .move_req(move_req), .move_cmd(move_cmd),
        .line_clear_active(line_clear_active), .game_over(game_over),
        .gravity_tick(gravity_tick), .move_grant(move_grant), .move_cmd_out(move_cmd_out),
        .state(state), .level(level), .lines(lines)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // steps until gravity_tick; n = steps taken (-1 on timeout), g = grants seen meanwhile
    task automatic wait_tick(output int n, output int g);
        n = -1;
        g = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (move_grant) g++;
            if (gravity_tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_clear(input int n);
        line_clear_active = 1'b1;
        repeat (n) step();
        line_clear_active = 1'b0;
        step();
    endtask

    always @(negedge clk) begin
        if (mon_en) check("tick_grant_excl", int'(gravity_tick && move_grant), 0);
    end

    initial begin
        int n, g, cnt;

        repeat (3) step();
        check("rst_state", int'(state), 0);
        check("rst_tick", int'(gravity_tick), 0);
        check("rst_grant", int'(move_grant), 0);
        check("rst_cmd", int'(move_cmd_out), 0);
        check("rst_level", int'(level), 0);
        check("rst_lines", int'(lines), 0);
        reset = 1'b0;
        mon_en = 1'b1;

        start = 1'b1; step(); start = 1'b0;
        check("start_state", int'(state), 1);
        wait_tick(n, g); check("tick_20", n, 20);
        wait_tick(n, g); check("tick_40", n, 20);
        wait_tick(n, g); check("tick_60", n, 20);
        soft_drop = 1'b1;
        wait_tick(n, g); check("soft_tick_65", n, 5);
        wait_tick(n, g); check("soft_tick_70", n, 5);
        soft_drop = 1'b0;

        cnt = 0;
        repeat (19) begin step(); if (gravity_tick) cnt++; end
        check("no_tick_71_89", cnt, 0);
        move_req = 1'b1; move_cmd = CMD_LEFT; step(); move_req = 1'b0;
        check("collide_tick", int'(gravity_tick), 1);
        check("collide_nogrant", int'(move_grant), 0);
        step();
        check("grant_91", int'(move_grant), 1);
        check("grant_91_cmd", int'(move_cmd_out), int'(CMD_LEFT));
        move_req = 1'b1; move_cmd = CMD_RIGHT; step(); move_req = 1'b0;
        check("gap_92", int'(move_grant), 0);
        step();
        check("gap_93", int'(move_grant), 0);
        step();
        check("grant_94", int'(move_grant), 1);
        check("grant_94_cmd", int'(move_cmd_out), int'(CMD_RIGHT));

        line_clear_active = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin move_req = 1'b1; move_cmd = CMD_DROP; end
            step();
            move_req = 1'b0;
            check("clear_state", int'(state), 3);
            check("clear_tick", int'(gravity_tick), (k != 0 && k % 2 == 0) ? 1 : 0);
            check("clear_nogrant", int'(move_grant), 0);
        end
        check("clear_lines", int'(lines), 1);
        line_clear_active = 1'b0;
        step();
        check("clear_exit_state", int'(state), 1);
        wait_tick(n, g);
        check("post_clear_tick", n, 20);
        check("post_clear_nogrant", g, 0);

        repeat (3) do_clear(1);
        check("lines_4", int'(lines), 4);
        check("level_2", int'(level), 2);
        wait_tick(n, g); check("p12_first", n, 12);
        wait_tick(n, g); check("p12_second", n, 12);
        repeat (2) do_clear(1);
        check("lines_6", int'(lines), 6);
        check("level_3", int'(level), 3);
        wait_tick(n, g); check("p8_first", n, 8);
        wait_tick(n, g); check("p8_second", n, 8);
        repeat (2) do_clear(1);
        check("lines_8", int'(lines), 8);
        check("level_sat", int'(level), 3);
        wait_tick(n, g); check("p8_sat", n, 8);

        game_over = 1'b1; step(); game_over = 1'b0;
        check("over_state", int'(state), 4);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            move_req = (i == 10);
            move_cmd = CMD_LEFT;
            step();
            if (gravity_tick || move_grant) cnt++;
        end
        move_req = 1'b0;
        check("over_quiet", cnt, 0);
        start = 1'b1; step(); start = 1'b0;
        check("restart_state", int'(state), 1);
        check("restart_lines", int'(lines), 0);
        check("restart_level", int'(level), 0);

        repeat (7) step();
        pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
        check("pause_state", int'(state), 2);
        cnt = 0;
        repeat (50) begin step(); if (gravity_tick) cnt++; end
        check("pause_quiet", cnt, 0);
        pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
        check("resume_state", int'(state), 1);
        wait_tick(n, g); check("resume_tick", n, 13);

        repeat (2) do_clear(1);
        check("pre_rst_level", int'(level), 1);
        step();
        move_req = 1'b1; move_cmd = CMD_ROTATE; reset = 1'b1;
        step();
        move_req = 1'b0; reset = 1'b0;
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_tick", int'(gravity_tick), 0);
        check("mid_rst_grant", int'(move_grant), 0);
        check("mid_rst_cmd", int'(move_cmd_out), 0);
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_lines", int'(lines), 0);
        step();
        check("idle_hold", int'(state), 0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1);
    end
endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
Top-level sequencer for the Tetris game executioner, running in the clk domain. It generates the one-cycle gravity_tick and move_grant enables that replace the free-running slow game_clk/move_clk. It arbitrates player moves against gravity so the two never coincide, and runs the game phase FSM (idle, run, pause, line-clear, game over). It tracks cleared lines and level, and shortens the gravity period as the level rises.

Parameters:
GRAVITY_BASE, 12_000_000, gravity period in clk cycles at level 0
GRAVITY_STEP, 1_000_000, period reduction per level
GRAVITY_MIN, 1_500_000, floor on gravity period (before soft-drop divide)
MAX_LEVEL, 9, level saturation value
LINES_PER_LEVEL, 10, cleared lines per level increment
MOVE_GAP, 2_000_000, minimum clk cycles between successive move grants
CLEAR_PERIOD, 500_000, gravity_tick spacing while in CLEAR
CNT_W, 24, width of period counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
start  input  1  one-cycle pulse; begins a new game from IDLE or OVER
pause_toggle  input  1  one-cycle pulse; RUN<->PAUSE
soft_drop  input  1  level; divides gravity period by 4
move_req  input  1  one-cycle pulse; player move request
move_cmd  input  tetris_pkg::command_t  command accompanying move_req
line_clear_active  input  1  level from executioner; high while a line clear is in progress
game_over  input  1  one-cycle pulse from executioner
gravity_tick  output  1  one-cycle enable; advance gravity / line-clear step
move_grant  output  1  one-cycle enable; apply move_cmd_out
move_cmd_out  output  tetris_pkg::command_t  granted command, valid when move_grant=1
state  output  3  0=IDLE 1=RUN 2=PAUSE 3=CLEAR 4=OVER
level  output  4  current level, 0..MAX_LEVEL
lines  output  16  total lines cleared, saturates at 16'hFFFF

Behaviour:
- Reset: state=IDLE; gravity_tick=0; move_grant=0; move_cmd_out=CMD_NONE (or value 0); level=0; lines=0. Gravity counter, gap counter, and pending-move buffer are cleared. Reset asserted mid-game returns to IDLE on the next edge.
- FSM transitions, priority top-down within a state:
  - IDLE: start -> RUN. No ticks, no grants.
  - RUN: game_over -> OVER; else line_clear_active -> CLEAR; else pause_toggle -> PAUSE.
  - PAUSE: game_over -> OVER; else pause_toggle -> RUN. Gravity and gap counters freeze and keep their values.
  - CLEAR: game_over -> OVER; else line_clear_active=0 -> RUN. pause_toggle is ignored.
  - OVER: start -> RUN. No ticks, no grants.
- Game start: on any start transition (IDLE->RUN or OVER->RUN), lines, level, gravity counter, gap counter, and pending buffer clear to 0.
- Gravity period (RUN):
  - P = max(GRAVITY_BASE - level*GRAVITY_STEP, GRAVITY_MIN).
  - If soft_drop=1, P >>= 2.
  - Counter increments each RUN cycle. When cnt >= P-1: gravity_tick=1 and cnt<=0. The >= handles P shrinking mid-count.
  - First tick occurs P cycles after entering RUN from start.
- CLEAR:
  - Gravity counter resets to 0 on entry. gravity_tick fires every CLEAR_PERIOD cycles.
  - On exit to RUN, the gravity counter resets to 0.
  - The pending move buffer is dropped on entry, and move_req is ignored while in CLEAR.
- Line and level accounting:
  - Each RUN->CLEAR transition increments lines by 1 (saturating).
  - A sub-counter wraps at LINES_PER_LEVEL. On each wrap, level increments, saturating at MAX_LEVEL.
  - The new level affects P from the next cycle.
- Move arbitration (RUN only):
  - move_req loads a 1-entry pending buffer. A newer request overwrites an unserviced one.
  - A grant is issued when the buffer is full, gap counter = 0, and gravity_tick is not firing this cycle.
  - Gravity wins a collision: the move stays pending and is granted on the next eligible cycle.
  - move_req and grant in the same cycle: the incoming request is granted directly (same cycle, combinational bypass of the empty buffer) if eligible; otherwise it is buffered.
  - A grant loads the gap counter with MOVE_GAP-1. The counter decrements to 0 and freezes in PAUSE.
  - The pending buffer persists across PAUSE and is cleared in IDLE and OVER.
- Invariants:
  - gravity_tick and move_grant are never both 1 in the same cycle.
  - Outputs are registered-state derived, with one-cycle pulses only.

Test Plan:
Overrides for all scenarios: GRAVITY_BASE=20, GRAVITY_STEP=4, GRAVITY_MIN=8, MAX_LEVEL=3, LINES_PER_LEVEL=2, MOVE_GAP=3, CLEAR_PERIOD=2.
- Reset, then start at cycle 0 -> state=1. gravity_tick at cycles 20, 40, 60. soft_drop held from cycle 60 -> next tick at 65, then every 5.
- move_req (CMD_LEFT) on the same cycle gravity_tick fires -> no grant that cycle; move_grant with CMD_LEFT the next cycle. A second move_req 1 cycle later is granted 3 cycles after the first grant.
- line_clear_active high for 6 cycles during RUN -> state=3, gravity_tick every 2 cycles, move_req ignored, lines=1. Then back to state=1 with the counter restarted.
- Clear sequences: 4 clears -> level=2, P=12 (verify tick spacing). 6 clears -> level=3, P=8. 8 clears -> level stays 3, lines=8.
- pause_toggle at RUN count=7 -> state=2, no ticks for 50 cycles. pause_toggle again -> next tick 13 cycles after resume.
- game_over in RUN -> state=4, no ticks or grants for 100 cycles. start -> state=1, lines=0, level=0. Reset asserted mid-RUN -> state=0, all outputs at reset values.
